// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: reset PC, instruction word width and the
// fetch FSM state encoding.
package rv_pkg;

    localparam int unsigned ILEN        = 32;
    localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction/PC FIFO between the memory response port and decode.
// Flush empties it in one cycle; push and pop together are legal when full.
module fetch_buf
    import rv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ILEN,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [ADDR_WIDTH-1:0] head_pc
);

    logic [DATA_WIDTH-1:0] r_data [2];
    logic [ADDR_WIDTH-1:0] r_pc   [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign full      = (r_count == 2'd2);
    assign empty     = (r_count == 2'd0);
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign head_data = r_data[r_rd_ptr];
    assign head_pc   = r_pc[r_rd_ptr];

    // Storage is cleared on reset so the head reads zero before the first fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_pc[0]   <= '0;
            r_pc[1]   <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else if (flush) begin
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_data[r_wr_ptr] <= push_data;
                r_pc[r_wr_ptr]   <= push_pc;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues sequential word fetches, buffers in-order
// responses for decode and handles redirects. Define INSTR_FETCH_PERF_EN to add
// the perf_fetched / perf_redirects counters.
module instr_fetch
    import rv_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = ILEN,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RV_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_redirects
`endif
);

    fetch_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_rsp_pc;
    logic [1:0]            r_outstanding;
    logic [1:0]            r_drop_cnt;

    logic                  w_req_fire;
    logic                  w_rsp_drop;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [1:0]            w_buf_cnt;
    logic [1:0]            w_out_next;
    logic [2:0]            w_inflight;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;

    assign w_req_fire    = imem_req_valid && imem_req_ready;
    assign w_rsp_drop    = redirect_valid || (r_state == FLUSH);
    assign w_push        = imem_rsp_valid && !w_rsp_drop;
    assign w_pop         = instr_valid && instr_ready;
    assign w_buf_cnt     = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);
    assign w_out_next    = r_outstanding + {1'b0, w_req_fire} - {1'b0, imem_rsp_valid};
    assign w_redirect_pc = redirect_pc & ~ADDR_WIDTH'(3);

    // A slot being popped this cycle counts as free, which keeps back-to-back delivery.
    assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_buf_cnt} - {2'b00, w_pop};
    assign imem_req_valid = (r_state == RUN) && (w_inflight < 3'd2);
    assign imem_req_addr  = r_fetch_pc;
    assign instr_valid    = !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= 2'd0;
            r_drop_cnt    <= 2'd0;
        end else begin
            r_outstanding <= w_out_next;
            // Everything still in flight after this cycle belongs to the old path.
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop_cnt <= w_out_next;
                r_state    <= (w_out_next != 2'd0) ? FLUSH : RUN;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + ADDR_WIDTH'(4);
                end
                case (r_state)
                    BOOT: r_state <= RUN;
                    RUN:  r_state <= RUN;
                    FLUSH: begin
                        if (imem_rsp_valid) begin
                            r_drop_cnt <= r_drop_cnt - 2'd1;
                            if (r_drop_cnt == 2'd1) begin
                                r_state <= RUN;
                            end
                        end
                    end
                    default: r_state <= BOOT;
                endcase
            end
        end
    end

    fetch_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fetch_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (imem_rsp_data),
        .push_pc   (r_rsp_pc),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .full      (w_full),
        .empty     (w_empty),
        .head_data (instr),
        .head_pc   (instr_pc)
    );

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_redirects;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched   <= 32'd0;
            r_perf_redirects <= 32'd0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (redirect_valid) begin
                r_perf_redirects <= r_perf_redirects + 32'd1;
            end
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_redirects = r_perf_redirects;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: an in-order memory model feeds the DUT
// and a scoreboard of expected {pc, data} is compared at each decode handshake.
module tb_instr_fetch;

    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rsp_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_redirects;
`endif

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects)
`endif
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } memReq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } expInstr_t;
    typedef struct { logic [31:0] pc; int cyc; } delivery_t;

    memReq_t     memQ[$];
    expInstr_t   sbQ[$];
    delivery_t   deliveryLog[$];
    logic [31:0] acceptLog[$];

    int          vectors     = 0;
    int          miscompares = 0;
    int          cycle       = 0;
    int          epoch       = 0;
    int          memLat      = 1;
    int          staleReqs   = 0;
    logic        memReady    = 1'b1;
    logic        decReady    = 1'b1;
    logic        redirPending = 1'b0;
    logic [31:0] redirTarget  = 32'h0;
    logic        redirOnRsp   = 1'b0;
    logic [31:0] redirOnRspTarget = 32'h0;
    logic [31:0] droppedPc    = 32'h0;
    logic        redirFired   = 1'b0;
    logic [31:0] expAddr      = RST_PC;
    logic        obsReqValid  = 1'b0;
    logic        obsInstrValid = 1'b0;
    logic [31:0] obsReqAddr   = 32'h0;

    function automatic logic [31:0] dataOf(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] deliveredPc(input int i);
        return (deliveryLog.size() > i) ? deliveryLog[i].pc : 32'hBADB_AD00;
    endfunction

    function automatic int deliveredCyc(input int i);
        return (deliveryLog.size() > i) ? deliveryLog[i].cyc : -100;
    endfunction

    function automatic logic [31:0] acceptedAddr(input int i);
        return (acceptLog.size() > i) ? acceptLog[i] : 32'hBADB_AD00;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs at negedge, observe just after, update the models.
    task automatic applyStimulus();
        memReq_t   head;
        expInstr_t e;
        logic      rspNow;
        logic      stale;
        int        oldEpoch;
        head = '{32'h0, 0, 0};
        @(negedge clk);
        rspNow = (memQ.size() > 0) && (memQ[0].due <= cycle);
        if (rspNow) head = memQ[0];
        if (redirOnRsp && rspNow) begin
            redirPending = 1'b1;
            redirTarget  = redirOnRspTarget;
            redirOnRsp   = 1'b0;
            droppedPc    = head.addr;
            redirFired   = 1'b1;
        end
        imem_rsp_valid = rspNow;
        imem_rsp_data  = rspNow ? dataOf(head.addr) : 32'h0;
        redirect_valid = redirPending;
        redirect_pc    = redirTarget;
        imem_req_ready = memReady;
        instr_ready    = decReady;
        #1;
        obsReqValid   = imem_req_valid;
        obsReqAddr    = imem_req_addr;
        obsInstrValid = instr_valid;

        if (instr_valid && instr_ready) begin
            deliveryLog.push_back('{instr_pc, cycle});
            if (sbQ.size() == 0) begin
                checkOutput("spurious_instr", 32'(instr_valid), 32'h0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("instr_pc", instr_pc, e.pc);
                checkOutput("instr_data", instr, e.data);
            end
        end

        oldEpoch = epoch;
        if (redirect_valid) begin
            sbQ.delete();
            epoch++;
        end

        if (rspNow) begin
            void'(memQ.pop_front());
            if (head.epoch == epoch) sbQ.push_back('{head.addr, dataOf(head.addr)});
        end

        if (imem_req_valid && imem_req_ready) begin
            stale = 1'b0;
            foreach (memQ[i]) if (memQ[i].epoch != epoch) stale = 1'b1;
            if (stale && !redirect_valid) staleReqs++;
            checkOutput("req_addr", imem_req_addr, expAddr);
            acceptLog.push_back(imem_req_addr);
            memQ.push_back('{imem_req_addr, oldEpoch, cycle + memLat});
            expAddr = expAddr + 32'd4;
        end
        if (redirect_valid) expAddr = redirTarget & ~32'h3;

        redirPending = 1'b0;
        cycle++;
    endtask

    task automatic assertReset();
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        memQ.delete();
        sbQ.delete();
        epoch++;
        expAddr      = RST_PC;
        redirPending = 1'b0;
        redirOnRsp   = 1'b0;
    endtask

    task automatic releaseReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("boot_no_req", 32'(imem_req_valid), 32'h0);
    endtask

    initial begin
        int n;
        int c0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        #12;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);

        $display("[TB] streaming fetch, latency 1");
        memLat = 1; memReady = 1'b1; decReady = 1'b1;
        assertReset(); releaseReset();
        deliveryLog.delete();
        c0 = cycle;
        repeat (8) applyStimulus();
        checkOutput("t1_pc0", deliveredPc(0), 32'h0);
        checkOutput("t1_pc1", deliveredPc(1), 32'h4);
        checkOutput("t1_pc2", deliveredPc(2), 32'h8);
        checkOutput("t1_first_latency", deliveredCyc(0) - c0, 32'd2);
        checkOutput("t1_gap01", deliveredCyc(1) - deliveredCyc(0), 32'd1);
        checkOutput("t1_gap12", deliveredCyc(2) - deliveredCyc(1), 32'd1);

        $display("[TB] decode stall for 10 cycles");
        assertReset(); releaseReset();
        decReady = 1'b0;
        acceptLog.delete();
        repeat (10) applyStimulus();
        checkOutput("t2_instr_valid", 32'(obsInstrValid), 32'h1);
        checkOutput("t2_req_valid_low", 32'(obsReqValid), 32'h0);
        checkOutput("t2_no_outstanding", memQ.size(), 32'd0);
        checkOutput("t2_fetched_two", acceptLog.size(), 32'd2);
        checkOutput("t2_head_pc", instr_pc, 32'h0);
        decReady = 1'b1;
        deliveryLog.delete();
        repeat (6) applyStimulus();
        checkOutput("t2_pc0", deliveredPc(0), 32'h0);
        checkOutput("t2_pc1", deliveredPc(1), 32'h4);
        checkOutput("t2_pc2", deliveredPc(2), 32'h8);

        $display("[TB] redirect with two outstanding");
        assertReset(); releaseReset();
        memLat = 3;
        n = 0;
        while (memQ.size() < 2 && n < 20) begin applyStimulus(); n++; end
        checkOutput("t3_two_outstanding", memQ.size(), 32'd2);
        redirPending = 1'b1; redirTarget = 32'h100;
        applyStimulus();
        deliveryLog.delete();
        applyStimulus();
        checkOutput("t3_flushed_instr_valid", 32'(obsInstrValid), 32'h0);
        checkOutput("t3_flush_no_req", 32'(obsReqValid), 32'h0);
        n = 0;
        while (deliveryLog.size() == 0 && n < 30) begin applyStimulus(); n++; end
        checkOutput("t3_first_pc", deliveredPc(0), 32'h100);

        $display("[TB] unaligned redirect and redirect on response");
        memLat = 1;
        repeat (4) applyStimulus();
        redirPending = 1'b1; redirTarget = 32'h203;
        applyStimulus();
        acceptLog.delete();
        n = 0;
        while (acceptLog.size() == 0 && n < 10) begin applyStimulus(); n++; end
        checkOutput("t4_aligned_addr", acceptedAddr(0), 32'h200);
        redirOnRsp = 1'b1; redirOnRspTarget = 32'h300; redirFired = 1'b0;
        n = 0;
        while (!redirFired && n < 10) begin applyStimulus(); n++; end
        checkOutput("t4_redirect_on_rsp", 32'(redirFired), 32'h1);
        deliveryLog.delete();
        n = 0;
        while (deliveryLog.size() == 0 && n < 20) begin applyStimulus(); n++; end
        checkOutput("t4_first_pc", deliveredPc(0), 32'h300);

        $display("[TB] request hold and address wrap");
        redirPending = 1'b1; redirTarget = 32'hFFFF_FFFC;
        applyStimulus();
        memReady = 1'b0;
        repeat (3) applyStimulus();
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("t5_hold_valid", 32'(obsReqValid), 32'h1);
            checkOutput("t5_hold_addr", obsReqAddr, 32'hFFFF_FFFC);
        end
        memReady = 1'b1;
        acceptLog.delete();
        n = 0;
        while (acceptLog.size() < 2 && n < 10) begin applyStimulus(); n++; end
        checkOutput("t5_addr_top", acceptedAddr(0), 32'hFFFF_FFFC);
        checkOutput("t5_addr_wrap", acceptedAddr(1), 32'h0000_0000);
        repeat (6) applyStimulus();

        $display("[TB] reset mid-transaction");
        memLat = 2;
        assertReset(); releaseReset();
        n = 0;
        while (!(obsInstrValid && obsReqValid) && n < 20) begin applyStimulus(); n++; end
        checkOutput("t6_busy", 32'(obsInstrValid && obsReqValid), 32'h1);
        assertReset();
        #1;
        checkOutput("t6_instr_valid", 32'(instr_valid), 32'h0);
        checkOutput("t6_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("t6_instr", instr, 32'h0);
        checkOutput("t6_instr_pc", instr_pc, 32'h0);
        releaseReset();
        acceptLog.delete();
        n = 0;
        while (acceptLog.size() == 0 && n < 10) begin applyStimulus(); n++; end
        checkOutput("t6_first_addr", acceptedAddr(0), RST_PC);
        repeat (6) applyStimulus();

        checkOutput("no_req_during_flush", staleReqs, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of all addresses and PCs.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of instruction words.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL have one clock and one asynchronous, active-low reset; ports as below.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 imem_req_valid  output  1  fetch request present.
REQ-008 imem_req_addr  output  ADDR_WIDTH  word-aligned fetch address.
REQ-009 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-010 imem_rsp_valid  input  1  in-order response, latency >= 1 cycle after acceptance.
REQ-011 imem_rsp_data  input  DATA_WIDTH  fetched instruction word.
REQ-012 redirect_valid  input  1  branch/jump taken; one-cycle pulse.
REQ-013 redirect_pc  input  ADDR_WIDTH  new fetch target.
REQ-014 instr_valid  output  1  instruction offered to the decode stage.
REQ-015 instr  output  DATA_WIDTH  instruction word to decode.
REQ-016 instr_pc  output  ADDR_WIDTH  PC of instr.
REQ-017 instr_ready  input  1  decode consumes instr this cycle.

Function
REQ-018 SHALL implement FSM states BOOT, RUN, FLUSH; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-019 SHALL transfer a request when imem_req_valid && imem_req_ready; fetch PC then advances by 4, wrapping modulo 2^ADDR_WIDTH.
REQ-020 SHALL assert imem_req_valid only in RUN and only when (outstanding + buffered) < 2, so the 2-entry buffer never overflows.
REQ-021 SHALL hold imem_req_addr stable while imem_req_valid is high and not accepted.
REQ-022 SHALL push each non-dropped response with its request PC into a 2-entry FIFO; FIFO head drives instr/instr_pc/instr_valid.
REQ-023 SHALL pop the head when instr_valid && instr_ready; pop and push in the same cycle SHALL be legal when full.
REQ-024 SHALL deliver a response with zero added latency: head valid the cycle after imem_rsp_valid when the FIFO was empty.
REQ-025 On redirect_valid: FIFO flushed, instr_valid low the next cycle, fetch PC <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}, drop count <= outstanding requests (including one accepted in the same cycle); state -> FLUSH if drop count nonzero, else RUN.
REQ-026 In FLUSH, no requests SHALL be issued; each arriving response decrements the drop count and is discarded; drop count reaching 0 -> RUN.
REQ-027 A response arriving in the redirect cycle SHALL be discarded and not counted in the drop count.
REQ-028 A redirect during FLUSH SHALL update the fetch PC and keep the remaining drop count.
REQ-029 instr_pc SHALL equal the address that fetched instr; PCs delivered between redirects SHALL be strictly +4 sequential.

Reset
REQ-030 rst_n low SHALL immediately clear imem_req_valid, instr_valid, FIFO, outstanding and drop counts, set state BOOT and fetch PC to RESET_PC.
REQ-031 Reset asserted mid-transaction SHALL abandon all outstanding requests; responses after reset release belong to the memory, which SHALL itself be in reset.
REQ-032 After reset, instr and instr_pc SHALL read 0.

Configuration
REQ-033 Macro INSTR_FETCH_PERF_EN, when defined, SHALL add outputs perf_fetched (32-bit, increments per instr handshake) and perf_redirects (32-bit, increments per redirect_valid), both reset to 0 and wrapping.
REQ-034 Without INSTR_FETCH_PERF_EN those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-035 RESET_PC default, FSM state encoding typedef, and the instruction-word width constant SHALL live in the shared package rv_pkg.
REQ-036 The 2-entry instruction/PC FIFO SHALL be a sub-module fetch_buf with push, pop, flush, full, empty.

Verification
REQ-037 Reset release, memory ready, latency 1, instr_ready=1 -> PCs 0x0,0x4,0x8 delivered on consecutive cycles after first response.
REQ-038 instr_ready=0 for 10 cycles -> exactly 2 instructions buffered, imem_req_valid low, no data lost; resume delivers 0x0,0x4,0x8 in order.
REQ-039 Redirect to 0x100 with 2 outstanding -> state FLUSH, both responses dropped, next delivered instr_pc = 0x100.
REQ-040 Redirect to 0x203 -> fetch address 0x200; redirect in same cycle as a response -> that response not delivered.
REQ-041 imem_req_ready low for 5 cycles -> imem_req_addr held stable; fetch PC 0xFFFF_FFFC followed by 0x0000_0000.
REQ-042 rst_n asserted while 2 requests outstanding -> instr_valid and imem_req_valid low same cycle; after release, first imem_req_addr = RESET_PC.
